// File: rtl/wavelet_filter_bank.sv
// rtl/wavelet_filter_bank.sv - multi-channel FIR wavelet bank sharing one sample history and one MAC
//
// Optional feature macro: WAVELET_SATURATE_EN
//   defined     -> shifted accumulator is clamped to the signed OUT_BITS range
//   not defined -> shifted accumulator is truncated to its low OUT_BITS bits (wraps)
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   i_value        signed sample, captured on the detected i_data_clk rising edge
//   i_data_clk     asynchronous sample strobe (rising edge = new sample)
//   i_coef_we      coefficient write strobe (IDLE only)
//   i_coef_addr    flat {channel, tap} coefficient address; tap 0 multiplies the newest sample
//   i_coef_data    signed coefficient
//   i_len_we       tap-length write strobe (IDLE only)
//   i_len_ch       channel whose tap length is written
//   i_len_val      tap count, clamped to MAX_TAPS
//   i_select       output channel select
//   o_wavelet_out  registered result[i_select], 0 for an out-of-range select
//   o_valid        one-cycle pulse when all channel results have been updated
//   o_busy         high while the FSM is not IDLE
//   o_overrun      sticky flag: a sample edge arrived while busy
//   o_active       0 in reset, 1 afterwards

module wavelet_filter_bank #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int MAX_TAPS      = 32,
  parameter int ACC_BITS      = 24,
  parameter int OUT_SHIFT     = 7,
  parameter int OUT_BITS      = 8,
  localparam int ADDR_W = (NUM_CHANNELS * MAX_TAPS > 1) ? $clog2(NUM_CHANNELS * MAX_TAPS) : 1,
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int LEN_W  = $clog2(MAX_TAPS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_PER_ELEM-1:0] i_value,
  input  logic                     i_data_clk,
  input  logic                     i_coef_we,
  input  logic [ADDR_W-1:0]        i_coef_addr,
  input  logic [BITS_PER_ELEM-1:0] i_coef_data,
  input  logic                     i_len_we,
  input  logic [CH_W-1:0]          i_len_ch,
  input  logic [LEN_W-1:0]         i_len_val,
  input  logic [7:0]               i_select,
  output logic [OUT_BITS-1:0]      o_wavelet_out,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_overrun,
  output logic                     o_active
);

  localparam int TAP_W  = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
  localparam int DEPTH  = NUM_CHANNELS * MAX_TAPS;
  localparam int PROD_W = 2 * BITS_PER_ELEM;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_STORE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Strobe synchroniser: bits 0..1 are the 2-FF synchroniser, bit 2 holds the
  // previous synchronised level for rising-edge detection.
  logic [2:0] dclk_sync;
  logic       data_edge;

  logic signed [BITS_PER_ELEM-1:0] hist   [MAX_TAPS];
  logic signed [BITS_PER_ELEM-1:0] coef   [DEPTH];
  logic        [LEN_W-1:0]         len    [NUM_CHANNELS];
  logic        [OUT_BITS-1:0]      result [NUM_CHANNELS];

  logic signed [BITS_PER_ELEM-1:0] sample_q;
  logic signed [ACC_BITS-1:0]      acc_q;
  logic        [CH_W-1:0]          ch_q;
  logic        [TAP_W-1:0]         tap_q;
  logic                            overrun_q;
  logic                            active_q;
  logic        [OUT_BITS-1:0]      out_q;

  logic        [CH_W-1:0]          next_ch;
  logic        [LEN_W-1:0]         cur_len;
  logic        [LEN_W-1:0]         next_len;
  logic                            last_tap;
  logic                            last_ch;
  logic        [ADDR_W-1:0]        coef_idx;
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_BITS-1:0]      prod_ext;
  logic signed [ACC_BITS-1:0]      shifted;
  logic        [OUT_BITS-1:0]      fmt_val;
  logic                            coef_wr_ok;
  logic                            len_wr_ok;

  assign data_edge = dclk_sync[1] & ~dclk_sync[2];

  assign next_ch  = ch_q + 1'b1;
  assign cur_len  = len[ch_q];
  assign next_len = len[next_ch];
  assign last_tap = (LEN_W'(tap_q) + LEN_W'(1)) == cur_len;
  assign last_ch  = 32'(ch_q) == NUM_CHANNELS - 1;

  // Coefficient storage is flat: channel c, tap t lives at c*MAX_TAPS + t.
  assign coef_idx = ADDR_W'(32'(ch_q) * MAX_TAPS + 32'(tap_q));
  assign prod     = coef[coef_idx] * hist[tap_q];
  assign prod_ext = {{(ACC_BITS - PROD_W){prod[PROD_W-1]}}, prod};

  assign shifted = acc_q >>> OUT_SHIFT;

`ifdef WAVELET_SATURATE_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    fmt_val = shifted[OUT_BITS-1:0];
    if (shifted > SAT_MAX) begin
      fmt_val = SAT_MAX[OUT_BITS-1:0];
    end else if (shifted < SAT_MIN) begin
      fmt_val = SAT_MIN[OUT_BITS-1:0];
    end
  end
`else
  assign fmt_val = shifted[OUT_BITS-1:0];
`endif

  // Configuration is only accepted while idle so a running pass always sees
  // a consistent coefficient/length set.
  assign coef_wr_ok = i_coef_we && (state_q == S_IDLE) && (32'(i_coef_addr) < DEPTH);
  assign len_wr_ok  = i_len_we && (state_q == S_IDLE) && (32'(i_len_ch) < NUM_CHANNELS);

  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_sync <= '0;
    end else begin
      dclk_sync <= {dclk_sync[1:0], i_data_clk};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_edge) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A zero-length channel skips MAC entirely.
        state_d = (len[0] == '0) ? S_STORE : S_MAC;
      end
      S_MAC: begin
        if (last_tap) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (last_ch) begin
          state_d = S_DONE;
        end else begin
          state_d = (next_len == '0) ? S_STORE : S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      acc_q    <= '0;
      ch_q     <= '0;
      tap_q    <= '0;
      for (int i = 0; i < MAX_TAPS; i++) begin
        hist[i] <= '0;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        result[c] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          acc_q <= '0;
          ch_q  <= '0;
          tap_q <= '0;
          if (data_edge) begin
            sample_q <= i_value;
          end
        end
        S_SHIFT: begin
          hist[0] <= sample_q;
          for (int i = 1; i < MAX_TAPS; i++) begin
            hist[i] <= hist[i-1];
          end
        end
        S_MAC: begin
          acc_q <= acc_q + prod_ext;
          tap_q <= tap_q + 1'b1;
        end
        S_STORE: begin
          result[ch_q] <= fmt_val;
          acc_q        <= '0;
          tap_q        <= '0;
          ch_q         <= last_ch ? '0 : next_ch;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        coef[i] <= '0;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        len[c] <= '0;
      end
    end else begin
      if (coef_wr_ok) begin
        coef[i_coef_addr] <= i_coef_data;
      end
      if (len_wr_ok) begin
        len[i_len_ch] <= (32'(i_len_val) > MAX_TAPS) ? LEN_W'(MAX_TAPS) : i_len_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      active_q  <= 1'b0;
      out_q     <= '0;
    end else begin
      active_q <= 1'b1;
      // Edges seen outside IDLE (including DONE) are dropped and flagged.
      if (data_edge && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (32'(i_select) < NUM_CHANNELS) begin
        out_q <= result[i_select[CH_W-1:0]];
      end else begin
        out_q <= '0;
      end
    end
  end

  assign o_wavelet_out = out_q;
  assign o_valid       = (state_q == S_DONE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_overrun     = overrun_q;
  assign o_active      = active_q;

endmodule

// File: tb/tb_wavelet_filter_bank.sv
// tb/tb_wavelet_filter_bank.sv - directed self-checking bench for wavelet_filter_bank

module tb_wavelet_filter_bank;

  logic       clk;
  logic       rst;
  logic [7:0] i_value;
  logic       i_data_clk;
  logic       i_coef_we;
  logic [6:0] i_coef_addr;
  logic [7:0] i_coef_data;
  logic       i_len_we;
  logic [1:0] i_len_ch;
  logic [5:0] i_len_val;
  logic [7:0] i_select;
  logic [7:0] o_wavelet_out;
  logic       o_valid;
  logic       o_busy;
  logic       o_overrun;
  logic       o_active;

  int total;
  int bad;

  wavelet_filter_bank dut (
    .clk           (clk),
    .rst           (rst),
    .i_value       (i_value),
    .i_data_clk    (i_data_clk),
    .i_coef_we     (i_coef_we),
    .i_coef_addr   (i_coef_addr),
    .i_coef_data   (i_coef_data),
    .i_len_we      (i_len_we),
    .i_len_ch      (i_len_ch),
    .i_len_val     (i_len_val),
    .i_select      (i_select),
    .o_wavelet_out (o_wavelet_out),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun),
    .o_active      (o_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_coef(input logic [6:0] addr, input logic [7:0] data);
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = addr;
    i_coef_data = data;
    @(negedge clk);
    i_coef_we   = 1'b0;
  endtask

  task automatic wr_len(input logic [1:0] ch, input logic [5:0] val);
    @(negedge clk);
    i_len_we  = 1'b1;
    i_len_ch  = ch;
    i_len_val = val;
    @(negedge clk);
    i_len_we  = 1'b0;
  endtask

  task automatic wr_both(input logic [6:0] addr, input logic [7:0] data,
                         input logic [1:0] ch, input logic [5:0] val);
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = addr;
    i_coef_data = data;
    i_len_we    = 1'b1;
    i_len_ch    = ch;
    i_len_val   = val;
    @(negedge clk);
    i_coef_we   = 1'b0;
    i_len_we    = 1'b0;
  endtask

  // Raises the strobe at cycle 0 and watches a fixed 150-cycle window.
  // extra: second strobe edge mid-computation; busy_wr: config writes while busy.
  task automatic sample_run(input logic [7:0] val, input bit extra, input bit busy_wr,
                            output int v_first, output int v_cnt,
                            output int b_first, output int b_last);
    v_first = -1;
    v_cnt   = 0;
    b_first = -1;
    b_last  = -1;
    @(negedge clk);
    i_value    = val;
    i_data_clk = 1'b1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      if (o_valid) begin
        if (v_first < 0) v_first = cyc;
        v_cnt++;
      end
      if (o_busy) begin
        if (b_first < 0) b_first = cyc;
        b_last = cyc;
      end
      if (cyc == 5) i_data_clk = 1'b0;
      if (extra && cyc == 9) begin
        i_value    = 8'd5;
        i_data_clk = 1'b1;
      end
      if (extra && cyc == 14) i_data_clk = 1'b0;
      if (busy_wr && cyc == 6) begin
        i_coef_we   = 1'b1;
        i_coef_addr = 7'd2;
        i_coef_data = 8'h00;
        i_len_we    = 1'b1;
        i_len_ch    = 2'd0;
        i_len_val   = 6'd0;
      end
      if (busy_wr && cyc == 7) begin
        i_coef_we = 1'b0;
        i_len_we  = 1'b0;
      end
    end
  endtask

  task automatic read_out(input logic [7:0] sel, output logic [7:0] v);
    @(negedge clk);
    i_select = sel;
    @(negedge clk);
    @(negedge clk);
    v = o_wavelet_out;
  endtask

  initial begin
    int         vf, vc, bf, bl;
    logic [7:0] r;

    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    i_value     = '0;
    i_data_clk  = 1'b0;
    i_coef_we   = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    i_len_we    = 1'b0;
    i_len_ch    = '0;
    i_len_val   = '0;
    i_select    = '0;

    // Reset state and first cycle after release
    repeat (3) @(negedge clk);
    check("rst_out", o_wavelet_out, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_active", o_active, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_active", o_active, 1);
    check("rel_valid", o_valid, 0);
    check("rel_busy", o_busy, 0);
    check("rel_overrun", o_overrun, 0);
    check("rel_out", o_wavelet_out, 0);

    // ch0 = {-57, 127, -57}; ch2 has a coefficient but length 0
    wr_coef(7'd0, 8'hC7);
    wr_coef(7'd1, 8'h7F);
    wr_coef(7'd2, 8'hC7);
    wr_coef(7'd64, 8'h7F);
    wr_len(2'd0, 6'd3);
    wr_len(2'd2, 6'd0);

    sample_run(8'd100, 1'b0, 1'b0, vf, vc, bf, bl);
    check("t2_vcyc", vf, 11);
    check("t2_vcnt", vc, 1);
    read_out(8'd0, r);
    check("t2_s1", r, 8'hD3);
    read_out(8'd2, r);
    check("t2_len0", r, 8'h00);
    read_out(8'd9, r);
    check("t2_sel9", r, 8'h00);

    // Config writes during this run must be ignored
    sample_run(8'd0, 1'b0, 1'b1, vf, vc, bf, bl);
    read_out(8'd0, r);
    check("t2_s2", r, 8'h63);
    sample_run(8'd0, 1'b0, 1'b0, vf, vc, bf, bl);
    read_out(8'd0, r);
    check("t2_s3_busywr", r, 8'hD3);
    sample_run(8'd0, 1'b0, 1'b0, vf, vc, bf, bl);
    read_out(8'd0, r);
    check("t2_s4", r, 8'h00);

    // Timing with lengths 3,5,9,15
    do_reset();
    wr_len(2'd0, 6'd3);
    wr_len(2'd1, 6'd5);
    wr_len(2'd2, 6'd9);
    wr_len(2'd3, 6'd15);
    sample_run(8'd1, 1'b0, 1'b0, vf, vc, bf, bl);
    check("t3_vcyc", vf, 40);
    check("t3_vcnt", vc, 1);
    check("t3_bfirst", bf, 3);
    check("t3_blast", bl, 40);

    // Output formatting: 3 x 127*127
    do_reset();
    wr_coef(7'd0, 8'h7F);
    wr_coef(7'd1, 8'h7F);
    wr_both(7'd2, 8'h7F, 2'd0, 6'd3);
    sample_run(8'd127, 1'b0, 1'b0, vf, vc, bf, bl);
    read_out(8'd0, r);
    check("t4_s1", r, 8'h7E);
    sample_run(8'd127, 1'b0, 1'b0, vf, vc, bf, bl);
    read_out(8'd0, r);
`ifdef WAVELET_SATURATE_EN
    check("t4_s2", r, 8'h7F);
`else
    check("t4_s2", r, 8'hFC);
`endif
    sample_run(8'd127, 1'b0, 1'b0, vf, vc, bf, bl);
    read_out(8'd0, r);
`ifdef WAVELET_SATURATE_EN
    check("t4_s3", r, 8'h7F);
`else
    check("t4_s3", r, 8'h7A);
`endif

    // Overrun: extra edge mid-MAC is dropped
    wr_len(2'd1, 6'd15);
    wr_len(2'd2, 6'd9);
    check("t5_pre_ovr", o_overrun, 0);
    sample_run(8'd0, 1'b1, 1'b0, vf, vc, bf, bl);
    check("t5_vcyc", vf, 35);
    check("t5_vcnt", vc, 1);
    check("t5_ovr", o_overrun, 1);
    read_out(8'd0, r);
`ifdef WAVELET_SATURATE_EN
    check("t5_r1", r, 8'h7F);
`else
    check("t5_r1", r, 8'hFC);
`endif
    sample_run(8'd0, 1'b0, 1'b0, vf, vc, bf, bl);
    read_out(8'd0, r);
    check("t5_r2", r, 8'h7E);
    check("t5_ovr_sticky", o_overrun, 1);

    // Length clamp: 63 -> 32 taps
    wr_len(2'd0, 6'd63);
    wr_len(2'd1, 6'd0);
    wr_len(2'd2, 6'd0);
    sample_run(8'd0, 1'b0, 1'b0, vf, vc, bf, bl);
    check("clamp_vcyc", vf, 40);
    check("clamp_ovr", o_overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
